// File: rtl/ha_array_sum_pipe.sv
// ha_array_sum_pipe
//   Final-addition stage behind the unsigned 8x8 approximate multiplier's
//   half-adder array. It takes the four array rows (bottom/carry vector b,
//   top/sum vector t) and forms the weighted sum, which is the approximate
//   product. The sum is built in a three-register pipeline with a valid/ready
//   handshake on both sides and a counter of products taken downstream.
//
//   Row weighting: R_i = (t_i << 2i) + (b_i << (2i+2)),
//                  product = R_0 + R_1 + R_2 + R_3  (max 86615, 17 bits).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake for the array rows
//   ha_array_{0..3}_b [6:0] row bottom (carry) vectors
//   ha_array_{0..3}_t [8:0] row top (sum) vectors
//   clr                     synchronous clear of prod_cnt
//   out_valid / out_ready   downstream handshake for product
//   product  [OUT_W-1:0]    weighted sum
//   prod_cnt [CNT_W-1:0]    products accepted downstream (wraps)
module ha_array_sum_pipe #(
  parameter int CNT_W = 16,
  parameter int OUT_W = 17   // only 17 is supported
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic [CNT_W-1:0] prod_cnt
);

  // Stage 1: raw array rows
  logic       v1;
  logic [6:0] s1_b0, s1_b1, s1_b2, s1_b3;
  logic [8:0] s1_t0, s1_t1, s1_t2, s1_t3;

  // Stage 2: partial sums of the lower and upper row pairs
  logic             v2;
  logic [12:0]      s2_p01;
  logic [OUT_W-1:0] s2_p23;

  // Stage 3: final product
  logic             v3;
  logic [OUT_W-1:0] s3_prod;

  // Load enables chain back from the output so that any empty stage can be
  // filled even while the output is stalled (bubble collapse).
  logic ld1, ld2, ld3;
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  // Row values, zero-extended to the width of the partial sum they feed.
  logic [12:0]      r0, r1, p01;
  logic [OUT_W-1:0] r2, r3, p23, sum;

  always_comb begin
    // NOTE: combinational logic uses blocking '=', every clocked register
    // below uses non-blocking '<=' so all stages update from pre-edge values.
    r0  = {4'b0, s1_t0}       + {4'b0, s1_b0, 2'b00};
    r1  = {2'b0, s1_t1, 2'b0} + {2'b0, s1_b1, 4'b0};
    r2  = {4'b0, s1_t2, 4'b0} + {4'b0, s1_b2, 6'b0};
    r3  = {2'b0, s1_t3, 6'b0} + {2'b0, s1_b3, 8'b0};
    p01 = r0 + r1;
    p23 = r2 + r3;
    sum = {4'b0, s2_p01} + s2_p23;
  end

  // NOTE: data registers are reset too (not only the valids) because product
  // must read 0 during and right after reset and never expose X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      s1_b0 <= '0; s1_b1 <= '0; s1_b2 <= '0; s1_b3 <= '0;
      s1_t0 <= '0; s1_t1 <= '0; s1_t2 <= '0; s1_t3 <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      // Data is only captured on a real transfer, so undriven inputs while
      // in_valid is low never reach the pipeline.
      if (in_valid) begin
        s1_b0 <= ha_array_0_b; s1_t0 <= ha_array_0_t;
        s1_b1 <= ha_array_1_b; s1_t1 <= ha_array_1_t;
        s1_b2 <= ha_array_2_b; s1_t2 <= ha_array_2_t;
        s1_b3 <= ha_array_3_b; s1_t3 <= ha_array_3_t;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      s2_p01 <= '0;
      s2_p23 <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_p01 <= p01;
        s2_p23 <= p23;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      s3_prod <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) s3_prod <= sum;
    end
  end

  assign out_valid = v3;
  assign product   = s3_prod;

  // Accepted-product counter; clr wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_cnt <= '0;
    end else if (clr) begin
      prod_cnt <= '0;
    end else if (v3 && out_ready) begin
      prod_cnt <= prod_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ha_array_sum_pipe.sv
// Directed testbench for ha_array_sum_pipe. Inputs are packed into one
// 64-bit vector: row i occupies bits [16i+15:16i] as {b_i[6:0], t_i[8:0]}.
module tb_ha_array_sum_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] vec;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] product;
  logic [15:0] prod_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ha_array_sum_pipe #(.CNT_W(16), .OUT_W(17)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (vec[8:0]),
    .ha_array_0_b (vec[15:9]),
    .ha_array_1_t (vec[24:16]),
    .ha_array_1_b (vec[31:25]),
    .ha_array_2_t (vec[40:32]),
    .ha_array_2_b (vec[47:41]),
    .ha_array_3_t (vec[56:48]),
    .ha_array_3_b (vec[63:57]),
    .clr          (clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .prod_cnt     (prod_cnt)
  );

  // Reference: add the weight of every set bit individually.
  function automatic logic [31:0] model(input logic [63:0] v);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 9; j++) if (v[16*i + j])     s += 1 << (2*i + j);
      for (int k = 0; k < 7; k++) if (v[16*i + 9 + k]) s += 1 << (2*i + k + 2);
    end
    return 32'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated vector with out_ready high: accept, then expect it in S3
  // after the third register edge and not earlier.
  task automatic send_one(input string tag, input logic [63:0] v, input logic [31:0] exp);
    vec = v;
    in_valid = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    vec = '0;
    step();
    chk({tag, " early"}, 32'(out_valid), 0);
    step();
    chk({tag, " out_valid"}, 32'(out_valid), 1);
    chk({tag, " product"}, 32'(product), exp);
    step();
  endtask

  logic [63:0] svec [20];
  logic [63:0] bvec [5];
  int rx;
  int sent;
  logic acc;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr = 1'b0;
    vec = '0;
    for (int i = 0; i < 20; i++) svec[i] = {$urandom, $urandom};
    for (int i = 0; i < 5; i++)  bvec[i] = {$urandom, $urandom};

    // Reset state
    #2;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst product", 32'(product), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst prod_cnt", 32'(prod_cnt), 0);
    #10 rst_n = 1'b1;
    step();
    chk("post-rst in_ready", 32'(in_ready), 1);

    // Single-bit weights and extremes
    send_one("t0 bit0", 64'h1, 1);
    send_one("t2 bit0", 64'h1_0000_0000, 16);
    send_one("b0 bit0", 64'h200, 4);
    send_one("b3 ones", 64'hFE00_0000_0000_0000, 32512);
    send_one("all ones", '1, 86615);
    send_one("all zero", '0, 0);
    chk("cnt after singles", 32'(prod_cnt), 6);

    // Streaming, out_ready held high
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr idle", 32'(prod_cnt), 0);
    rx = 0;
    for (int c = 0; c < 40 && rx < 20; c++) begin
      if (c < 20) begin
        vec = svec[c];
        in_valid = 1'b1;
        chk("stream in_ready", 32'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        chk("stream product", 32'(product), model(svec[rx]));
        rx++;
      end
    end
    in_valid = 1'b0;
    chk("stream count", 32'(rx), 20);
    step();
    chk("stream prod_cnt", 32'(prod_cnt), 20);
    chk("stream drained", 32'(out_valid), 0);

    // Backpressure: three vectors fill the pipe, the fourth is refused.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vec = bvec[k];
      in_valid = 1'b1;
      chk("bp in_ready fill", 32'(in_ready), 1);
      step();
    end
    vec = bvec[3];
    chk("bp in_ready full", 32'(in_ready), 0);
    chk("bp out_valid", 32'(out_valid), 1);
    chk("bp product head", 32'(product), model(bvec[0]));
    step();
    step();
    chk("bp still full", 32'(in_ready), 0);
    chk("bp product hold", 32'(product), model(bvec[0]));
    chk("bp cnt hold", 32'(prod_cnt), 20);

    out_ready = 1'b1;
    rx = 0;
    sent = 3;
    for (int c = 0; c < 30 && rx < 5; c++) begin
      if (sent < 5) begin
        vec = bvec[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #0;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("bp drain product", 32'(product), model(bvec[rx]));
        rx++;
      end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp drain count", 32'(rx), 5);
    chk("bp prod_cnt", 32'(prod_cnt), 25);
    chk("bp empty", 32'(out_valid), 0);

    // Counter wrap: stream until the counter reads its maximum.
    clr = 1'b1;
    step();
    clr = 1'b0;
    vec = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (prod_cnt == 16'hFFFF) break;
      step();
    end
    chk("cnt reach max", 32'(prod_cnt), 32'hFFFF);
    chk("cnt wrap xfer pending", 32'(out_valid), 1);
    step();
    chk("cnt wrap 0", 32'(prod_cnt), 0);
    step();
    chk("cnt wrap 1", 32'(prod_cnt), 1);
    clr = 1'b1;
    chk("clr xfer pending", 32'(out_valid), 1);
    step();
    clr = 1'b0;
    chk("clr beats xfer", 32'(prod_cnt), 0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("cnt after drain", 32'(prod_cnt), 3);

    // Reset mid-operation with three results in flight
    for (int k = 0; k < 3; k++) begin
      vec = svec[k];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("pre-rst out_valid", 32'(out_valid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst product", 32'(product), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst prod_cnt", 32'(prod_cnt), 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no stale out_valid", 32'(out_valid), 0);
    end
    send_one("after rst", svec[5], model(svec[5]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
